// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Purpose:
//   Turns decoded instruction descriptors (class, function, payload) into
//   19-bit instruction words, buffers them in a small FIFO and writes them
//   sequentially into instruction memory starting at a programmable base
//   address. The test harness and boot path use it to load programs.
//
//   Word layout: word[18:13] = opcode, word[12:0] = in_payload.
//   The opcode prefixes are prefix-free, so the Controller recovers the class
//   from the leading bits of every emitted word.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start               one-cycle pulse in IDLE: latch base_addr/count
//   base_addr [ADDR_W]  first memory address written
//   count     [CNT_W]   number of words to load (0 -> straight to DONE)
//   in_valid/in_ready   descriptor handshake
//   in_class  [3]       0=REG 1=IMM 2=MEM 3=CJMP 4=JMP, 5-7 illegal
//   in_fn     [4]       function field
//   in_payload[13]      operand bits, copied to word[12:0]
//   imem_we/imem_ready  memory write handshake
//   imem_addr [ADDR_W]  write address
//   imem_wdata[19]      encoded word
//   busy                state is LOAD
//   done                one-cycle pulse after the last word is written
//   err_illegal         sticky; set on an illegal class, cleared by start
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        in_fn,
  input  logic [12:0]       in_payload,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [18:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  // Opcode prefixes shared with the Controller's decoder.
  localparam logic [1:0] REGISTER_TYPE_OPCODE            = 2'b00;
  localparam logic [1:0] IMMEDIATE_TYPE_OPCODE           = 2'b01;
  localparam logic [2:0] MEMORY_TYPE_OPCODE              = 3'b100;
  localparam logic [2:0] CONDITIONAL_JUMP_TYPE_OPCODE    = 3'b101;
  localparam logic [3:0] NO_CONDITIONAL_JUMP_TYPE_OPCODE = 4'b1100;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W:0]    PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  logic              err_q, err_d;

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [18:0]       fifo_mem [FIFO_DEPTH];

  logic [5:0]        enc_opcode;
  logic              enc_legal;
  logic [18:0]       enc_word;
  logic [18:0]       fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              start_ok;

  // ---------------- encoder (combinational on the input) ----------------
  always_comb begin
    enc_opcode = '0;
    enc_legal  = 1'b1;
    case (in_class)
      3'd0:    enc_opcode = {REGISTER_TYPE_OPCODE, in_fn};
      3'd1:    enc_opcode = {IMMEDIATE_TYPE_OPCODE, in_fn};
      3'd2:    enc_opcode = {MEMORY_TYPE_OPCODE, in_fn[1:0], 1'b0};
      3'd3:    enc_opcode = {CONDITIONAL_JUMP_TYPE_OPCODE, in_fn[2:0]};
      3'd4:    enc_opcode = {NO_CONDITIONAL_JUMP_TYPE_OPCODE, in_fn[1:0]};
      default: enc_legal  = 1'b0;
    endcase
  end

  assign enc_word = {enc_opcode, in_payload};

  // ---------------- FIFO ----------------
  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  assign accept   = in_valid && in_ready;
  // Illegal descriptors complete the handshake but never enter the FIFO.
  assign push     = accept && enc_legal;
  assign pop      = imem_we && imem_ready;
  assign start_ok = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= enc_word;
    end
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    accepted_d  = accepted_q;
    err_d       = err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (start_ok) begin
      addr_d      = base_addr;
      remaining_d = count;
      count_d     = count;
      accepted_d  = '0;
      err_d       = 1'b0;
    end else begin
      if (pop) begin
        addr_d      = addr_q + ADDR_ONE;       // wraps modulo 2^ADDR_W
        remaining_d = remaining_q - CNT_ONE;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        accepted_d = accepted_q + CNT_ONE;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
      end
      if (accept && !enc_legal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      accepted_q  <= '0;
      err_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      accepted_q  <= accepted_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Leave as the final word is taken by memory.
        if ((remaining_q == '0) || (pop && (remaining_q == CNT_ONE))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (state_q == ST_LOAD);
    done        = (state_q == ST_DONE);
    imem_we     = (state_q == ST_LOAD) && !fifo_empty;
    in_ready    = (state_q == ST_LOAD) && !fifo_full && (accepted_q < count_q);
    imem_addr   = addr_q;
    // Gated so the bus reads zero whenever no write is offered.
    imem_wdata  = imem_we ? fifo_head : '0;
    err_illegal = err_q;
  end

endmodule
